// File: rtl/ysyx_24080014_mem_ctrl_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
package ysyx_24080014_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Illegal size, or a half/word that does not sit on its natural boundary.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_X) || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    store_mask = 4'b0001 << off;
      SZ_H:    store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every lane the mask can select carries it.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    store_data = {4{wdata[7:0]}};
      SZ_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  // Pick the addressed lane out of the word, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic zext,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [15:0] lane;
    lane = 16'(word >> {off, 3'b000});
    case (size)
      SZ_B:    load_extend = zext ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    load_extend = zext ? {16'd0, lane} : {{16{lane[15]}}, lane};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24080014_mem_ctrl_if.sv
// LSU request/response channels plus the physical-memory access port.
interface ysyx_24080014_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Memory port: a read or write happens at the closing edge of a cycle with ren/wen high.
  logic        pmem_ren;
  logic        pmem_wen;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output pmem_ren, pmem_wen, pmem_addr, pmem_wdata, pmem_wmask,
    input  pmem_rdata
  );

  modport mem (
    input  pmem_ren, pmem_wen, pmem_addr, pmem_wdata, pmem_wmask,
    output pmem_rdata
  );
endinterface

// File: rtl/ysyx_24080014_mem_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to randomise access latency.
module ysyx_24080014_lfsr8
  import ysyx_24080014_mem_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);
  logic [7:0] state_reg;

  // Shift left every cycle out of reset, feeding the tap parity into bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SEED;
    end else begin
      state_reg <= {state_reg[6:0], ^(state_reg & LFSR_TAPS)};
    end
  end

  assign state = state_reg;
endmodule

// File: rtl/ysyx_24080014_mem_ctrl.sv
// Single-outstanding load/store controller with programmable access latency.
module ysyx_24080014_mem_ctrl
  import ysyx_24080014_mem_pkg::*;
#(
  parameter int unsigned DELAY      = 1,
  parameter int unsigned RAND_DELAY = 0,
  parameter int unsigned DELAY_BITS = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_24080014_mem_ctrl_if.slave bus
);
  state_e      state_reg;
  logic [3:0]  cnt_reg;
  logic        wen_reg;
  logic        uns_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [7:0]  lfsr_state;
  logic        lfsr_unused;
  logic [3:0]  rand_wait;
  logic [3:0]  wait_sel;
  logic        req_bad;
  logic        accept;

  ysyx_24080014_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  // Only the low DELAY_BITS of the LFSR form the random wait; the rest is spare.
  assign rand_wait   = lfsr_state[3:0] & 4'((5'd1 << DELAY_BITS) - 5'd1);
  assign lfsr_unused = ^lfsr_state[7:4];
  assign wait_sel    = (RAND_DELAY != 0) ? rand_wait : 4'(DELAY);
  assign req_bad     = req_illegal(bus.req_size, bus.req_addr[1:0]);
  assign accept      = (state_reg == ST_IDLE) && bus.req_valid;

  // Sequencing: accept, optional countdown, one access cycle, hold response until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cnt_reg <= wait_sel;
            if (req_bad)                state_reg <= ST_RESP;
            else if (wait_sel == 4'd0)  state_reg <= ST_ACCESS;
            else                        state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= ST_ACCESS;
        end
        ST_ACCESS: state_reg <= ST_RESP;
        ST_RESP:   if (bus.resp_ready) state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  // Capture the request at the accept edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_reg   <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= SZ_B;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      wen_reg   <= bus.req_wen;
      uns_reg   <= bus.req_unsigned;
      size_reg  <= bus.req_size;
      addr_reg  <= bus.req_addr;
      wdata_reg <= bus.req_wdata;
    end
  end

  // Response payload: error flag straight from accept, load data from the access edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (accept && req_bad) begin
      rdata_reg <= '0;
      err_reg   <= 1'b1;
    end else if (state_reg == ST_ACCESS) begin
      err_reg   <= 1'b0;
      rdata_reg <= wen_reg ? '0 : load_extend(size_reg, uns_reg, addr_reg[1:0], bus.pmem_rdata);
    end
  end

  assign bus.req_ready  = (state_reg == ST_IDLE) && rst;
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;

  // Memory is touched only during ACCESS, which reset and errored requests never reach.
  assign bus.pmem_ren   = (state_reg == ST_ACCESS) && !wen_reg;
  assign bus.pmem_wen   = (state_reg == ST_ACCESS) && wen_reg;
  assign bus.pmem_addr  = {addr_reg[31:2], 2'b00};
  assign bus.pmem_wmask = store_mask(size_reg, addr_reg[1:0]);
  assign bus.pmem_wdata = store_data(size_reg, wdata_reg);
endmodule

// File: tb/tb_ysyx_24080014_mem_ctrl.sv
// Scoreboard bench: three controllers (fixed wait 1, fixed wait 0, LFSR wait) on one memory model.
module tb_ysyx_24080014_mem_ctrl;
  import ysyx_24080014_mem_pkg::*;

  typedef struct packed {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          edge0;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req_valid = 3'b000;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = SZ_W;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b1;

  logic [2:0]  req_ready_w, resp_valid_w, resp_err_w, ren_w, wen_w;
  logic [31:0] rdata_w [3];
  logic [31:0] paddr_w [3];
  logic [31:0] pwdata_w [3];
  logic [3:0]  wmask_w [3];

  logic [31:0] mem [16];
  logic        mem_clr = 1'b1;
  int          wcalls = 0, rcalls = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_mask = '0;

  int   edge_cnt = 0;
  logic [7:0] lfsr_m;
  int   errors = 0, checks = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic pend = 1'b0;
  int   hold_left = 0;
  int   done_cnt = 0;

  ysyx_24080014_mem_ctrl_if bus[3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_conn
      assign bus[gi].req_valid    = req_valid[gi];
      assign bus[gi].req_wen      = req_wen;
      assign bus[gi].req_size     = req_size;
      assign bus[gi].req_unsigned = req_unsigned;
      assign bus[gi].req_addr     = req_addr;
      assign bus[gi].req_wdata    = req_wdata;
      assign bus[gi].resp_ready   = resp_ready;
      assign bus[gi].pmem_rdata   = mem[bus[gi].pmem_addr[5:2]];
      assign req_ready_w[gi]      = bus[gi].req_ready;
      assign resp_valid_w[gi]     = bus[gi].resp_valid;
      assign resp_err_w[gi]       = bus[gi].resp_err;
      assign rdata_w[gi]          = bus[gi].resp_rdata;
      assign ren_w[gi]            = bus[gi].pmem_ren;
      assign wen_w[gi]            = bus[gi].pmem_wen;
      assign paddr_w[gi]          = bus[gi].pmem_addr;
      assign pwdata_w[gi]         = bus[gi].pmem_wdata;
      assign wmask_w[gi]          = bus[gi].pmem_wmask;
    end
  endgenerate

  ysyx_24080014_mem_ctrl #(.DELAY(1), .RAND_DELAY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  ysyx_24080014_mem_ctrl #(.DELAY(0), .RAND_DELAY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus[1]));
  ysyx_24080014_mem_ctrl #(.DELAY(1), .RAND_DELAY(1), .DELAY_BITS(3), .LFSR_SEED(8'hA5))
    dut2 (.clk(clk), .rst(rst), .bus(bus[2]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference LFSR: taps 8,6,5,4, shifting left.
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 8'hA5;
    else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Simulated physical memory and access log.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (rst && wen_w[i]) begin
        for (int b = 0; b < 4; b++)
          if (wmask_w[i][b]) mem[paddr_w[i][5:2]][8*b +: 8] <= pwdata_w[i][8*b +: 8];
        wcalls     <= wcalls + 1;
        last_addr  <= paddr_w[i];
        last_mask  <= wmask_w[i];
        last_wdata <= pwdata_w[i];
      end else if (rst && ren_w[i]) begin
        rcalls <= rcalls + 1;
      end
    end
  end

  // Monitor: pops the expectation when a response appears and checks it until handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && resp_valid_w[i]) begin
        if (!pend) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", {31'd0, resp_valid_w[i]}, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            pend = 1'b1;
            hold_left = cur.hold;
            chk("resp_inst", i, cur.inst);
            chk("resp_latency", edge_cnt - cur.edge0, cur.lat);
          end
        end
        if (pend) begin
          chk("resp_rdata", rdata_w[i], cur.rdata);
          chk("resp_err", {31'd0, resp_err_w[i]}, {31'd0, cur.err});
          chk("req_ready_in_resp", {31'd0, req_ready_w[i]}, 32'd0);
          if (hold_left > 0) begin
            resp_ready = 1'b0;
            hold_left--;
          end else begin
            resp_ready = 1'b1;
            pend = 1'b0;
            done_cnt++;
            $display("resp inst=%0d rdata=%08h err=%0d lat=%0d", i, rdata_w[i], resp_err_w[i],
                     edge_cnt - cur.edge0);
          end
        end
      end
    end
  end

  task automatic issue(input int inst, input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    int n;
    int d0;
    n = 0;
    @(negedge clk);
    while (!req_ready_w[inst] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready_w[inst]}, 32'd1);
    req_wen = wen;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid[inst] = 1'b1;
    e.inst  = inst;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.edge0 = edge_cnt;
    e.hold  = hold;
    if (exp_err)        e.lat = 1;
    else if (inst == 2) e.lat = int'(lfsr_m[2:0]) + 2;
    else if (inst == 0) e.lat = 3;
    else                e.lat = 2;
    exp_q.push_back(e);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    req_valid[inst] = 1'b0;
    // Scramble inputs after acceptance; the captured request must not change.
    req_addr = ~addr;
    req_wdata = ~wdata;
    req_size = ~size;
    req_wen = ~wen;
    req_unsigned = ~uns;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_wait", done_cnt - d0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, rc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", {31'd0, req_ready_w[i]}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid_w[i]}, 32'd0);
      chk("rst_resp_rdata", rdata_w[i], 32'd0);
      chk("rst_resp_err", {31'd0, resp_err_w[i]}, 32'd0);
    end
    mem_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {29'd0, req_ready_w}, 32'd7);

    // Stores on the DELAY=1 controller.
    issue(0, 1'b1, SZ_W, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    chk("sw_addr", last_addr, 32'h8000_0004);
    chk("sw_mask", {28'd0, last_mask}, 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    issue(0, 1'b1, SZ_B, 1'b0, 32'h8000_0006, 32'h0000_00AB, 32'h0, 1'b0, 0);
    chk("sb_addr", last_addr, 32'h8000_0004);
    chk("sb_mask", {28'd0, last_mask}, 32'h4);
    chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("write_calls", wcalls, 32'd2);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAB_BEEF, 1'b0, 0);

    // Loads on the DELAY=0 controller.
    issue(1, 1'b0, SZ_H, 1'b0, 32'h8000_0006, 32'h0, 32'hFFFF_DEAB, 1'b0, 0);
    issue(1, 1'b0, SZ_H, 1'b1, 32'h8000_0006, 32'h0, 32'h0000_DEAB, 1'b0, 0);
    issue(1, 1'b0, SZ_B, 1'b0, 32'h8000_0004, 32'h0, 32'hFFFF_FFEF, 1'b0, 0);
    issue(1, 1'b0, SZ_B, 1'b1, 32'h8000_0007, 32'h0, 32'h0000_00DE, 1'b0, 0);
    issue(1, 1'b0, SZ_H, 1'b0, 32'h8000_0004, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);

    // Error requests never reach memory.
    wc = wcalls;
    rc = rcalls;
    issue(0, 1'b0, SZ_W, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 0);
    issue(0, 1'b0, SZ_X, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 1'b1, 0);
    issue(1, 1'b0, SZ_H, 1'b1, 32'h8000_0007, 32'h0, 32'h0, 1'b1, 0);
    issue(1, 1'b1, SZ_H, 1'b0, 32'h8000_0005, 32'h0000_1234, 32'h0, 1'b1, 0);
    chk("err_read_calls", rcalls, rc);
    chk("err_write_calls", wcalls, wc);
    chk("err_mem_intact", mem[1], 32'hDEAB_BEEF);

    // Half store then word readback.
    issue(1, 1'b1, SZ_H, 1'b0, 32'h8000_0008, 32'hFFFF_1234, 32'h0, 1'b0, 0);
    chk("sh_mask", {28'd0, last_mask}, 32'h3);
    chk("sh_wdata", last_wdata, 32'h1234_1234);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h8000_0008, 32'h0, 32'h0000_1234, 1'b0, 0);

    // Back-pressure: response held for 5 cycles, then a back-to-back request.
    issue(0, 1'b0, SZ_B, 1'b1, 32'h8000_0005, 32'h0, 32'h0000_00BE, 1'b0, 5);
    issue(0, 1'b0, SZ_H, 1'b1, 32'h8000_0004, 32'h0, 32'h0000_BEEF, 1'b0, 0);

    // LFSR-timed loads.
    for (int k = 0; k < 20; k++) begin
      issue(2, 1'b0, SZ_W, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAB_BEEF, 1'b0, 0);
    end

    // Reset while a store is waiting: nothing is written, no response appears.
    wc = wcalls;
    @(negedge clk);
    req_wen = 1'b1;
    req_size = SZ_W;
    req_addr = 32'h8000_0000;
    req_wdata = 32'h1111_1111;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("wait_req_ready", {31'd0, req_ready_w[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready_w[0]}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid_w[0]}, 32'd0);
    chk("abort_resp_rdata", rdata_w[0], 32'd0);
    chk("abort_resp_err", {31'd0, resp_err_w[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_write", wcalls, wc);
    chk("abort_mem_intact", mem[0], 32'd0);
    chk("post_rst_req_ready", {31'd0, req_ready_w[0]}, 32'd1);
    chk("post_rst_resp_valid", {31'd0, resp_valid_w[0]}, 32'd0);
    chk("leftover_expect", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
